// File: rtl/spi_cmem_pkg.sv
// Shared opcodes and FSM state encoding for the Raspberry Pi SPI port into cmem.
package spi_cmem_pkg;

  localparam logic [3:0] OP_WRITE = 4'h0;
  localparam logic [3:0] OP_READ  = 4'h1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CMD    = 3'd1,
    WDATA  = 3'd2,
    RDATA  = 3'd3,
    IGNORE = 3'd4
  } state_t;

endpackage

// File: rtl/spi_in_sync.sv
// Multi-stage synchronizer for one asynchronous SPI pin, with registered
// one-cycle rise/fall pulses derived from its last two stages.
module spi_in_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk200,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   rise_r;
  logic                   fall_r;

  // synchronizer chain and edge compare; cleared to the idle-low pin state
  always_ff @(posedge clk200) begin
    if (reset) begin
      sync_r <= '0;
      rise_r <= 1'b0;
      fall_r <= 1'b0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], din};
      rise_r <= sync_r[SYNC_STAGES-2] & ~sync_r[SYNC_STAGES-1];
      fall_r <= ~sync_r[SYNC_STAGES-2] & sync_r[SYNC_STAGES-1];
    end
  end

  assign level = sync_r[SYNC_STAGES-1];
  assign rise  = rise_r;
  assign fall  = fall_r;

endmodule

// File: rtl/spi_cmem_port.sv
// Mode-0 SPI slave bridging the Raspberry Pi link to cmem's nibble read/write port.
// Frames bytes from oversampled pins, decodes commands and returns read data on MISO.
module spi_cmem_port
  import spi_cmem_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk200,
  input  logic       reset,
  input  logic       SPI_SCK,
  input  logic       SPI_SS_n,
  input  logic       SPI_MOSI,
  output logic       SPI_MISO,
  output logic       spi_read,
  output logic       spi_write,
  output logic [3:0] spi_address,
  output logic [3:0] spi_out_cmem_in,
  input  logic [3:0] spi_in_cmem_out
);

  logic sck_lvl_s, sck_rise_s, sck_fall_s;
  logic ss_lvl_s, ss_rise_s, ss_fall_s;
  logic mosi_s, mosi_rise_s, mosi_fall_s;
  logic unused_s;

  state_t     state_r, state_s;
  logic [2:0] bit_cnt_r;
  logic [6:0] shift_r;
  logic [7:0] rx_byte_s;
  logic       byte_done_s;
  logic [3:0] waddr_r, waddr_s;
  logic       spi_read_r, rd_s;
  logic       spi_write_r, wr_s;
  logic [3:0] spi_address_r, addr_s;
  logic [3:0] wdata_r, wdata_s;
  logic       cap_pend_r;
  logic [7:0] tx_r;
  logic       miso_r;
  logic       miso_en_r;

  spi_in_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sck (
    .clk200(clk200), .reset(reset), .din(SPI_SCK),
    .level(sck_lvl_s), .rise(sck_rise_s), .fall(sck_fall_s)
  );

  spi_in_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ss (
    .clk200(clk200), .reset(reset), .din(SPI_SS_n),
    .level(ss_lvl_s), .rise(ss_rise_s), .fall(ss_fall_s)
  );

  spi_in_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk200(clk200), .reset(reset), .din(SPI_MOSI),
    .level(mosi_s), .rise(mosi_rise_s), .fall(mosi_fall_s)
  );

  assign unused_s    = ^{sck_lvl_s, ss_lvl_s, mosi_rise_s, mosi_fall_s};
  assign rx_byte_s   = {shift_r, mosi_s};
  assign byte_done_s = sck_rise_s && (bit_cnt_r == 3'd7) && (state_r != IDLE);

  // state register
  always_ff @(posedge clk200) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // next-state and strobe decode; SS_n edges override any byte in flight
  always_comb begin
    state_s = state_r;
    rd_s    = 1'b0;
    wr_s    = 1'b0;
    addr_s  = spi_address_r;
    wdata_s = wdata_r;
    waddr_s = waddr_r;
    if (ss_rise_s) begin
      state_s = IDLE;
    end else if (ss_fall_s) begin
      state_s = CMD;
    end else if (byte_done_s) begin
      case (state_r)
        CMD: begin
          if (rx_byte_s[7:4] == OP_WRITE) begin
            state_s = WDATA;
            waddr_s = rx_byte_s[3:0];
          end else if (rx_byte_s[7:4] == OP_READ) begin
            state_s = RDATA;
            rd_s    = 1'b1;
            addr_s  = rx_byte_s[3:0];
          end else begin
            state_s = IGNORE;
          end
        end
        WDATA: begin
          wr_s    = 1'b1;
          addr_s  = waddr_r;
          wdata_s = rx_byte_s[3:0];
          waddr_s = waddr_r + 4'd1;
        end
        RDATA, IGNORE: state_s = state_r;
        default:       state_s = IDLE;
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // byte framing and registered cmem strobes
  always_ff @(posedge clk200) begin
    if (reset) begin
      bit_cnt_r     <= 3'd0;
      shift_r       <= 7'd0;
      waddr_r       <= 4'd0;
      spi_read_r    <= 1'b0;
      spi_write_r   <= 1'b0;
      spi_address_r <= 4'd0;
      wdata_r       <= 4'd0;
      cap_pend_r    <= 1'b0;
    end else begin
      spi_read_r    <= rd_s;
      spi_write_r   <= wr_s;
      spi_address_r <= addr_s;
      wdata_r       <= wdata_s;
      waddr_r       <= waddr_s;
      cap_pend_r    <= spi_read_r;
      if (ss_rise_s || ss_fall_s) begin
        bit_cnt_r <= 3'd0;
      end else if (sck_rise_s && (state_r != IDLE)) begin
        bit_cnt_r <= bit_cnt_r + 3'd1;
        shift_r   <= rx_byte_s[6:0];
      end
    end
  end

  // MISO shifter: read data lands before the next SCK fall, which presents its MSB
  always_ff @(posedge clk200) begin
    if (reset) begin
      miso_en_r <= 1'b0;
      miso_r    <= 1'b0;
      tx_r      <= 8'h00;
    end else if (ss_rise_s) begin
      miso_en_r <= 1'b0;
      miso_r    <= 1'b0;
      tx_r      <= 8'h00;
    end else if (ss_fall_s) begin
      miso_en_r <= 1'b1;
      miso_r    <= 1'b0;
      tx_r      <= 8'h00;
    end else if (cap_pend_r) begin
      tx_r <= {4'h0, spi_in_cmem_out};
    end else if (sck_fall_s && miso_en_r) begin
      miso_r <= tx_r[7];
      tx_r   <= {tx_r[6:0], 1'b0};
    end
  end

  assign SPI_MISO        = miso_en_r ? miso_r : 1'bz;
  assign spi_read        = spi_read_r;
  assign spi_write       = spi_write_r;
  assign spi_address     = spi_address_r;
  assign spi_out_cmem_in = wdata_r;

endmodule

// File: tb/tb_spi_cmem_port.sv
// Self-checking bench for spi_cmem_port: an SPI master, a 1-cycle-latency cmem
// model, and a transaction-level reference model of the expected strobes and MISO bytes.
`timescale 1ns/100ps
module tb_spi_cmem_port;

  logic       clk200 = 1'b0;
  logic       reset;
  logic       SPI_SCK, SPI_SS_n, SPI_MOSI;
  wire        miso_w;
  logic       spi_read, spi_write;
  logic [3:0] spi_address, spi_out_cmem_in;
  logic [3:0] cmem_dout = 4'h0;

  pullup (miso_w);

  spi_cmem_port #(.SYNC_STAGES(2)) dut (
    .clk200(clk200), .reset(reset),
    .SPI_SCK(SPI_SCK), .SPI_SS_n(SPI_SS_n), .SPI_MOSI(SPI_MOSI), .SPI_MISO(miso_w),
    .spi_read(spi_read), .spi_write(spi_write), .spi_address(spi_address),
    .spi_out_cmem_in(spi_out_cmem_in), .spi_in_cmem_out(cmem_dout)
  );

  always #2.5 clk200 = ~clk200;

  int n_checks = 0;
  int n_pass   = 0;
  int half_cyc = 4;

  logic [3:0] cmem [16] = '{default: 4'h0};
  logic [3:0] ref_mem [16] = '{default: 4'h0};
  logic [3:0] wr_a[$], wr_d[$], rd_a[$];
  int         both_cnt = 0;

  logic [7:0] tx_q[$], rx_q[$];
  logic [3:0] exp_wa[$], exp_wd[$], exp_ra[$];
  logic [7:0] exp_miso[$];

  // cmem model: write on strobe, read data valid one cycle after spi_read
  always @(posedge clk200) begin
    if (spi_write) begin
      cmem[spi_address] <= spi_out_cmem_in;
      wr_a.push_back(spi_address);
      wr_d.push_back(spi_out_cmem_in);
    end
    if (spi_read) begin
      cmem_dout <= cmem[spi_address];
      rd_a.push_back(spi_address);
    end
    if (spi_read && spi_write) both_cnt++;
  end

  // Transaction-level model: complete bytes only; write data goes to addr, addr+1, ...
  task automatic model_tx(input int partial);
    int n;
    logic [3:0] op, a;
    exp_wa.delete(); exp_wd.delete(); exp_ra.delete(); exp_miso.delete();
    n = (partial > 0) ? tx_q.size() - 1 : tx_q.size();
    if (n > 0) begin
      op = tx_q[0][7:4];
      a  = tx_q[0][3:0];
      if (op == 4'h1) exp_ra.push_back(a);
      for (int i = 0; i < n; i++) begin
        if (op == 4'h1 && i == 1) exp_miso.push_back({4'h0, ref_mem[a]});
        else exp_miso.push_back(8'h00);
        if (op == 4'h0 && i > 0) begin
          exp_wa.push_back(a);
          exp_wd.push_back(tx_q[i][3:0]);
          ref_mem[a] = tx_q[i][3:0];
          a = a + 4'd1;
        end
      end
    end
  endtask

  // Mode-0 master: MOSI changes with SCK low, MISO sampled just before each rise.
  task automatic xfer(input int partial, input bit hold);
    logic [7:0] rx;
    int nb;
    rx_q.delete();
    SPI_SS_n = 1'b0;
    repeat ($urandom_range(12, 2)) @(negedge clk200);
    for (int i = 0; i < tx_q.size(); i++) begin
      nb = (partial > 0 && i == tx_q.size() - 1) ? partial : 8;
      rx = 8'h00;
      for (int k = 0; k < nb; k++) begin
        SPI_MOSI = tx_q[i][7-k];
        repeat (half_cyc) @(negedge clk200);
        rx = {rx[6:0], miso_w};
        SPI_SCK = 1'b1;
        repeat (half_cyc) @(negedge clk200);
        SPI_SCK = 1'b0;
      end
      if (nb == 8) rx_q.push_back(rx);
    end
    if (!hold) begin
      repeat (half_cyc) @(negedge clk200);
      SPI_SS_n = 1'b1;
      repeat (10) @(negedge clk200);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; SPI_SS_n = 1'b1; SPI_SCK = 1'b0; SPI_MOSI = 1'b0;
    repeat (5) @(negedge clk200);
    n_checks++; if (spi_read !== 1'b0) $display("FAIL rst_read got %b want 0", spi_read); else n_pass++;
    n_checks++; if (spi_write !== 1'b0) $display("FAIL rst_write got %b want 0", spi_write); else n_pass++;
    n_checks++; if (spi_address !== 4'h0) $display("FAIL rst_addr got %h want 0", spi_address); else n_pass++;
    n_checks++; if (spi_out_cmem_in !== 4'h0) $display("FAIL rst_wdata got %h want 0", spi_out_cmem_in); else n_pass++;
    n_checks++; if (miso_w !== 1'b1) $display("FAIL rst_miso_off got %b want released(1)", miso_w); else n_pass++;
    reset = 1'b0;
    repeat (5) @(negedge clk200);
  endtask

  task automatic test_single_write();
    int wb, rb;
    half_cyc = 4; tx_q = '{8'h0D, 8'h05}; model_tx(0);
    wb = wr_a.size(); rb = rd_a.size();
    xfer(0, 1'b0);
    n_checks++; if (wr_a.size() - wb != 1) $display("FAIL t1_nwrites got %0d want 1", wr_a.size() - wb); else n_pass++;
    n_checks++; if (wr_a[wb] !== 4'd13 || wr_d[wb] !== 4'd5) $display("FAIL t1_write got (%0d,%0d) want (13,5)", wr_a[wb], wr_d[wb]); else n_pass++;
    n_checks++; if (rd_a.size() != rb) $display("FAIL t1_noread got %0d reads want 0", rd_a.size() - rb); else n_pass++;
  endtask

  task automatic test_addr_wrap();
    int wb;
    half_cyc = 50; tx_q = '{8'h0E, 8'hA1, 8'hB2, 8'hC3}; model_tx(0);
    wb = wr_a.size();
    xfer(0, 1'b0);
    n_checks++; if (wr_a.size() - wb != 3) $display("FAIL t2_nwrites got %0d want 3", wr_a.size() - wb); else n_pass++;
    n_checks++; if (wr_a[wb] !== 4'd14 || wr_d[wb] !== 4'd1) $display("FAIL t2_w0 got (%0d,%0d) want (14,1)", wr_a[wb], wr_d[wb]); else n_pass++;
    n_checks++; if (wr_a[wb+1] !== 4'd15 || wr_d[wb+1] !== 4'd2) $display("FAIL t2_w1 got (%0d,%0d) want (15,2)", wr_a[wb+1], wr_d[wb+1]); else n_pass++;
    n_checks++; if (wr_a[wb+2] !== 4'd0 || wr_d[wb+2] !== 4'd3) $display("FAIL t2_wrap got (%0d,%0d) want (0,3)", wr_a[wb+2], wr_d[wb+2]); else n_pass++;
  endtask

  task automatic test_read();
    int wb, rb;
    half_cyc = 4; tx_q = '{8'h0C, 8'h09}; model_tx(0);
    xfer(0, 1'b0);
    tx_q = '{8'h1C, 8'h00, 8'h00}; model_tx(0);
    wb = wr_a.size(); rb = rd_a.size();
    xfer(0, 1'b0);
    n_checks++; if (rd_a.size() - rb != 1) $display("FAIL t3_nreads got %0d want 1", rd_a.size() - rb); else n_pass++;
    n_checks++; if (rd_a[rb] !== 4'd12) $display("FAIL t3_raddr got %0d want 12", rd_a[rb]); else n_pass++;
    n_checks++; if (wr_a.size() != wb) $display("FAIL t3_nowrite got %0d writes want 0", wr_a.size() - wb); else n_pass++;
    n_checks++; if (rx_q.size() != 3 || rx_q[0] !== 8'h00 || rx_q[1] !== 8'h09 || rx_q[2] !== 8'h00)
      $display("FAIL t3_miso got %h %h %h want 00 09 00", rx_q[0], rx_q[1], rx_q[2]); else n_pass++;
  endtask

  task automatic test_partial_byte();
    int wb;
    half_cyc = 4; tx_q = '{8'h03, 8'hA5}; model_tx(4);
    wb = wr_a.size();
    xfer(4, 1'b0);
    n_checks++; if (wr_a.size() != wb) $display("FAIL t4_partial got %0d writes want 0", wr_a.size() - wb); else n_pass++;
    tx_q = '{8'h03, 8'h07}; model_tx(0);
    wb = wr_a.size();
    xfer(0, 1'b0);
    n_checks++; if (wr_a.size() - wb != 1 || wr_a[wb] !== 4'd3 || wr_d[wb] !== 4'd7)
      $display("FAIL t4_next got %0d writes (%0d,%0d) want 1 (3,7)", wr_a.size() - wb, wr_a[wb], wr_d[wb]); else n_pass++;
  endtask

  task automatic test_ignore();
    int wb, rb;
    half_cyc = 50; tx_q = '{8'h5F, 8'hFF, 8'hFF}; model_tx(0);
    wb = wr_a.size(); rb = rd_a.size();
    xfer(0, 1'b0);
    n_checks++; if (wr_a.size() != wb || rd_a.size() != rb) $display("FAIL t5_strobes got %0d/%0d want 0/0", wr_a.size() - wb, rd_a.size() - rb); else n_pass++;
    n_checks++; if (rx_q.size() != 3 || (rx_q[0] | rx_q[1] | rx_q[2]) !== 8'h00)
      $display("FAIL t5_miso got %h %h %h want 00 00 00", rx_q[0], rx_q[1], rx_q[2]); else n_pass++;
    n_checks++; if (miso_w !== 1'b1) $display("FAIL t5_miso_release got %b want released(1)", miso_w); else n_pass++;
  endtask

  task automatic test_reset_mid_write();
    int wb;
    half_cyc = 4; tx_q = '{8'h0A, 8'h04}; model_tx(0);
    xfer(0, 1'b0);
    tx_q = '{8'h02, 8'h5C}; model_tx(4);
    wb = wr_a.size();
    xfer(4, 1'b1);
    reset = 1'b1;
    @(negedge clk200);
    n_checks++; if (spi_write !== 1'b0 || spi_read !== 1'b0) $display("FAIL t6_strobes got %b%b want 00", spi_read, spi_write); else n_pass++;
    n_checks++; if (spi_address !== 4'h0 || spi_out_cmem_in !== 4'h0)
      $display("FAIL t6_addr_data got (%h,%h) want (0,0)", spi_address, spi_out_cmem_in); else n_pass++;
    n_checks++; if (miso_w !== 1'b1) $display("FAIL t6_miso_off got %b want released(1)", miso_w); else n_pass++;
    repeat (2) @(negedge clk200);
    reset = 1'b0;
    repeat (3) @(negedge clk200);
    SPI_SS_n = 1'b1;
    repeat (10) @(negedge clk200);
    n_checks++; if (wr_a.size() != wb) $display("FAIL t6_aborted got %0d writes want 0", wr_a.size() - wb); else n_pass++;
    tx_q = '{8'h06, 8'h3A}; model_tx(0);
    xfer(0, 1'b0);
    n_checks++; if (wr_a.size() - wb != 1 || wr_a[wb] !== 4'd6 || wr_d[wb] !== 4'hA)
      $display("FAIL t6_after got %0d writes (%0d,%0d) want 1 (6,10)", wr_a.size() - wb, wr_a[wb], wr_d[wb]); else n_pass++;
  endtask

  task automatic test_random();
    int wb, rb, len, kind;
    for (int t = 0; t < 16; t++) begin
      half_cyc = ($urandom_range(1, 0) == 0) ? 4 : 50;
      kind = $urandom_range(2, 0);
      len  = $urandom_range(4, 1);
      tx_q.delete();
      if (kind == 0) tx_q.push_back({4'h0, 4'($urandom_range(15, 0))});
      else if (kind == 1) tx_q.push_back({4'h1, 4'($urandom_range(15, 0))});
      else tx_q.push_back(8'($urandom_range(255, 32)));
      for (int i = 1; i < len; i++) tx_q.push_back(8'($urandom_range(255, 0)));
      model_tx(0);
      wb = wr_a.size(); rb = rd_a.size();
      xfer(0, 1'b0);
      n_checks++; if (wr_a.size() - wb != exp_wa.size()) $display("FAIL rnd%0d_nwrites got %0d want %0d", t, wr_a.size() - wb, exp_wa.size()); else n_pass++;
      for (int i = 0; i < exp_wa.size(); i++) begin
        n_checks++; if (wr_a[wb+i] !== exp_wa[i] || wr_d[wb+i] !== exp_wd[i])
          $display("FAIL rnd%0d_w%0d got (%0d,%0d) want (%0d,%0d)", t, i, wr_a[wb+i], wr_d[wb+i], exp_wa[i], exp_wd[i]); else n_pass++;
      end
      n_checks++; if (rd_a.size() - rb != exp_ra.size() || (exp_ra.size() == 1 && rd_a[rb] !== exp_ra[0]))
        $display("FAIL rnd%0d_reads got %0d reads want %0d", t, rd_a.size() - rb, exp_ra.size()); else n_pass++;
      for (int i = 0; i < exp_miso.size(); i++) begin
        n_checks++; if (rx_q[i] !== exp_miso[i]) $display("FAIL rnd%0d_miso%0d got %h want %h", t, i, rx_q[i], exp_miso[i]); else n_pass++;
      end
    end
    n_checks++; if (both_cnt != 0) $display("FAIL both_strobes got %0d cycles want 0", both_cnt); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_addr_wrap();
    test_read();
    test_partial_byte();
    test_ignore();
    test_reset_mid_write();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
